load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  CPU-side initiator for data memory. Accepts one load/store request at a time from the
//  execute stage and drives a word-addressed, byte-enabled memory port with valid/ready
//  handshake and a separate response strobe. Aligns store data onto byte lanes and
//  sign/zero-extends load data. Misaligned accesses split into two word beats (optional).
// PARAMETERS
//  (none local; XLEN, LS_SEL_WIDTH and LS_TYPE_* codes come from memory.vh)
// PORTS
//  i_Clock            in   1               system clock, all logic on posedge
//  i_Reset            in   1               synchronous, active-high reset
//  i_Req_Valid        in   1               request from pipeline
//  o_Req_Ready        out  1               unit idle, request accepted when both high
//  i_Load_Store_Type  in   LS_SEL_WIDTH+1  LS_TYPE_* code
//  i_Addr             in   XLEN            byte address
//  i_Store_Data       in   XLEN            store data, LSB-justified
//  o_Resp_Valid       out  1               one-cycle completion pulse, no backpressure
//  o_Load_Data        out  XLEN            extended load result, valid with o_Resp_Valid
//  o_Fault            out  1               completion is a fault, valid with o_Resp_Valid
//  o_Mem_Valid        out  1               memory beat request
//  i_Mem_Ready        in   1               memory accepts beat
//  o_Mem_Write        out  1               1 = store beat
//  o_Mem_Addr         out  XLEN            word address, bits [1:0] always 0
//  o_Mem_Byte_Enable  out  4               lane enables (writes); reads return full word
//  o_Mem_Write_Data   out  XLEN            lane-aligned store data
//  i_Mem_Resp_Valid   in   1               read data / write ack for accepted beat
//  i_Mem_Read_Data    in   XLEN            full read word
// BEHAVIOUR
//  - Reset: state IDLE; o_Req_Ready=1 after reset; all other outputs 0.
//  - Request latched (type, addr, data) on posedge when i_Req_Valid & o_Req_Ready.
//  - o_Req_Ready = (state==IDLE); one request in flight, no queue.
//  - size: byte=1, half=2, word=4; off=addr[1:0]; mask=((1<<size)-1)<<off (8 bits).
//  - Beat LO: addr&~3, BE=mask[3:0], data=store_data<<(8*off).
//    Beat HI (only when mask[7:4]!=0): (addr&~3)+4 (wraps mod 2^XLEN), BE=mask[7:4],
//    data=store_data>>(8*(4-off)).
//  - States: IDLE -> REQ_LO -> WAIT_LO -> [REQ_HI -> WAIT_HI] -> RESP -> IDLE.
//    REQ_x: o_Mem_Valid=1, all o_Mem_* stable until i_Mem_Ready; advance on handshake.
//    WAIT_x: advance on i_Mem_Resp_Valid; LO read word -> lo_reg, HI -> hi_reg.
//    RESP: o_Resp_Valid=1 for exactly one cycle, then IDLE.
//  - Load result: ({hi_reg,lo_reg} >> 8*off) truncated to size, then sign-extended
//    (LOAD_BYTE/LOAD_HALF) or zero-extended (_UNSIGNED, LOAD_WORD none).
//    hi_reg treated as 0 when no HI beat. Stores: o_Load_Data=0.
//  - Memory response: at least one cycle after beat handshake; i_Mem_Resp_Valid
//    outside WAIT_x is ignored.
//  - Fault: invalid type code -> IDLE to RESP directly, o_Fault=1, o_Load_Data=0,
//    no memory beat issued.
//  - Latency (aligned, ready=1, response next cycle): accept edge T, o_Mem_Valid in T+1,
//    resp in T+2, o_Resp_Valid in T+3. Split access adds 2 cycles.
//  - Reset mid-operation: abandon transaction, IDLE next cycle, no o_Resp_Valid; late
//    memory responses ignored.
// CONFIGURATION
//  LSU_MISALIGNED_SPLIT_EN defined: spanning accesses split into LO+HI beats as above.
//  Not defined: any access with mask[7:4]!=0 faults (o_Fault=1, no memory beat, RESP
//  one cycle after accept); HI states not built.
// TESTING
//  1. LOAD_WORD @0x100, mem returns 0xDEADBEEF -> one beat addr 0x100; o_Load_Data=
//     0xDEADBEEF, o_Fault=0, o_Resp_Valid at T+3.
//  2. STORE_BYTE 0x000000A5 @0x203 -> beat addr 0x200, BE=4'b1000, data=0xA5000000,
//     o_Mem_Write=1; ack -> o_Resp_Valid pulse.
//  3. LOAD_BYTE @0x101 with word 0x0000_8000 -> 0xFFFFFF80; LOAD_BYTE_UNSIGNED -> 0x80.
//  4. (SPLIT_EN) LOAD_HALF @0x103, LO word 0xAB000000, HI word 0x000000CD -> beats 0x100,
//     0x104; result 0xFFFFCDAB. Without macro: o_Fault=1, no o_Mem_Valid.
//  5. i_Mem_Ready held 0 for 5 cycles in REQ_LO -> o_Mem_* stable, o_Req_Ready=0 throughout.
//  6. i_Reset in WAIT_LO, then i_Mem_Resp_Valid -> no o_Resp_Valid; o_Req_Ready=1 next cycle.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: single-request initiator for a word-addressed, byte-enabled data memory.
// Define LSU_MISALIGNED_SPLIT_EN to split word-spanning accesses into LO+HI beats (else they fault).
package lsu_pkg;
    // Stands in for memory.vh: datapath width and LS_TYPE_* codes {store, unsigned, size[1:0]}.
    localparam int XLEN         = 32;
    localparam int LS_SEL_WIDTH = 3;
    localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LOAD_BYTE          = 4'h0;
    localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LOAD_HALF          = 4'h1;
    localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LOAD_WORD          = 4'h2;
    localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LOAD_BYTE_UNSIGNED = 4'h4;
    localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LOAD_HALF_UNSIGNED = 4'h5;
    localparam logic [LS_SEL_WIDTH:0] LS_TYPE_STORE_BYTE         = 4'h8;
    localparam logic [LS_SEL_WIDTH:0] LS_TYPE_STORE_HALF         = 4'h9;
    localparam logic [LS_SEL_WIDTH:0] LS_TYPE_STORE_WORD         = 4'hA;
endpackage

module load_store_unit
    import lsu_pkg::*;
(
    input  logic                    i_Clock,
    input  logic                    i_Reset,
    input  logic                    i_Req_Valid,
    output logic                    o_Req_Ready,
    input  logic [LS_SEL_WIDTH:0]   i_Load_Store_Type,
    input  logic [XLEN-1:0]         i_Addr,
    input  logic [XLEN-1:0]         i_Store_Data,
    output logic                    o_Resp_Valid,
    output logic [XLEN-1:0]         o_Load_Data,
    output logic                    o_Fault,
    output logic                    o_Mem_Valid,
    input  logic                    i_Mem_Ready,
    output logic                    o_Mem_Write,
    output logic [XLEN-1:0]         o_Mem_Addr,
    output logic [3:0]              o_Mem_Byte_Enable,
    output logic [XLEN-1:0]         o_Mem_Write_Data,
    input  logic                    i_Mem_Resp_Valid,
    input  logic [XLEN-1:0]         i_Mem_Read_Data
);

`ifdef LSU_MISALIGNED_SPLIT_EN
    typedef enum logic [2:0] {IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, RESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ_LO, WAIT_LO, RESP} state_t;
`endif

    state_t                 state;
    logic [LS_SEL_WIDTH:0]  type_r;
    logic [1:0]             off_r;
    logic                   req_ok;
    logic                   req_fault;
    logic [3:0]             lanes;
    logic [7:0]             req_mask;
    logic [XLEN-1:0]        lo_w;
    logic [XLEN-1:0]        hi_w;
    logic [XLEN-1:0]        sh;
    logic [XLEN-1:0]        load_result;
`ifdef LSU_MISALIGNED_SPLIT_EN
    logic                   hi_pend;
    logic [XLEN-1:0]        hi_addr;
    logic [3:0]             hi_be;
    logic [XLEN-1:0]        hi_wd;
    logic [XLEN-1:0]        lo_reg;
`endif

    always_comb begin
        case (i_Load_Store_Type)
            LS_TYPE_LOAD_BYTE, LS_TYPE_LOAD_HALF, LS_TYPE_LOAD_WORD,
            LS_TYPE_LOAD_BYTE_UNSIGNED, LS_TYPE_LOAD_HALF_UNSIGNED,
            LS_TYPE_STORE_BYTE, LS_TYPE_STORE_HALF, LS_TYPE_STORE_WORD: req_ok = 1'b1;
            default: req_ok = 1'b0;
        endcase
        case (i_Load_Store_Type[1:0])
            2'd0:    lanes = 4'b0001;
            2'd1:    lanes = 4'b0011;
            default: lanes = 4'b1111;
        endcase
        req_mask = {4'b0000, lanes} << i_Addr[1:0];
`ifdef LSU_MISALIGNED_SPLIT_EN
        req_fault = !req_ok;
`else
        req_fault = !req_ok || (|req_mask[7:4]);
`endif
    end

    // Final read word arrives on the bus; the LO word is already held when a HI beat was needed.
    always_comb begin
        lo_w = i_Mem_Read_Data;
        hi_w = '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
        if (state == WAIT_HI) begin
            lo_w = lo_reg;
            hi_w = i_Mem_Read_Data;
        end
`endif
        sh = XLEN'({hi_w, lo_w} >> {off_r, 3'b000});
        case (type_r[1:0])
            2'd0:    load_result = type_r[2] ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'd1:    load_result = type_r[2] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: load_result = sh;
        endcase
        if (type_r[3])
            load_result = '0;
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state             <= IDLE;
            o_Req_Ready       <= 1'b1;
            o_Resp_Valid      <= 1'b0;
            o_Load_Data       <= '0;
            o_Fault           <= 1'b0;
            o_Mem_Valid       <= 1'b0;
            o_Mem_Write       <= 1'b0;
            o_Mem_Addr        <= '0;
            o_Mem_Byte_Enable <= '0;
            o_Mem_Write_Data  <= '0;
            type_r            <= '0;
            off_r             <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            hi_pend           <= 1'b0;
            hi_addr           <= '0;
            hi_be             <= '0;
            hi_wd             <= '0;
            lo_reg            <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (i_Req_Valid) begin
                    o_Req_Ready <= 1'b0;
                    type_r      <= i_Load_Store_Type;
                    off_r       <= i_Addr[1:0];
                    if (req_fault) begin
                        state        <= RESP;
                        o_Resp_Valid <= 1'b1;
                        o_Fault      <= 1'b1;
                    end else begin
                        state             <= REQ_LO;
                        o_Mem_Valid       <= 1'b1;
                        o_Mem_Write       <= i_Load_Store_Type[3];
                        o_Mem_Addr        <= {i_Addr[XLEN-1:2], 2'b00};
                        o_Mem_Byte_Enable <= req_mask[3:0];
                        o_Mem_Write_Data  <= i_Load_Store_Type[3] ? i_Store_Data << {i_Addr[1:0], 3'b000} : '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
                        hi_pend <= |req_mask[7:4];
                        hi_addr <= {i_Addr[XLEN-1:2], 2'b00} + XLEN'(4);
                        hi_be   <= req_mask[7:4];
                        hi_wd   <= i_Load_Store_Type[3] ? i_Store_Data >> (6'd32 - {1'b0, i_Addr[1:0], 3'b000}) : '0;
`endif
                    end
                end
                REQ_LO: if (i_Mem_Ready) begin
                    o_Mem_Valid <= 1'b0;
                    state       <= WAIT_LO;
                end
                WAIT_LO: if (i_Mem_Resp_Valid) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                    if (hi_pend) begin
                        lo_reg            <= i_Mem_Read_Data;
                        state             <= REQ_HI;
                        o_Mem_Valid       <= 1'b1;
                        o_Mem_Addr        <= hi_addr;
                        o_Mem_Byte_Enable <= hi_be;
                        o_Mem_Write_Data  <= hi_wd;
                    end else
`endif
                    begin
                        state        <= RESP;
                        o_Resp_Valid <= 1'b1;
                        o_Load_Data  <= load_result;
                    end
                end
`ifdef LSU_MISALIGNED_SPLIT_EN
                REQ_HI: if (i_Mem_Ready) begin
                    o_Mem_Valid <= 1'b0;
                    state       <= WAIT_HI;
                end
                WAIT_HI: if (i_Mem_Resp_Valid) begin
                    state        <= RESP;
                    o_Resp_Valid <= 1'b1;
                    o_Load_Data  <= load_result;
                end
`endif
                RESP: begin
                    state             <= IDLE;
                    o_Req_Ready       <= 1'b1;
                    o_Resp_Valid      <= 1'b0;
                    o_Load_Data       <= '0;
                    o_Fault           <= 1'b0;
                    o_Mem_Write       <= 1'b0;
                    o_Mem_Byte_Enable <= '0;
                    o_Mem_Write_Data  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: drives requests, plays a 1-cycle-latency memory, checks beats and results.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic                  i_Clock, i_Reset, i_Req_Valid, o_Req_Ready;
    logic [LS_SEL_WIDTH:0] i_Load_Store_Type;
    logic [31:0]           i_Addr, i_Store_Data, o_Load_Data, o_Mem_Addr, o_Mem_Write_Data, i_Mem_Read_Data;
    logic                  o_Resp_Valid, o_Fault, o_Mem_Valid, i_Mem_Ready, o_Mem_Write, i_Mem_Resp_Valid;
    logic [3:0]            o_Mem_Byte_Enable;

    load_store_unit dut (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Req_Valid(i_Req_Valid), .o_Req_Ready(o_Req_Ready),
        .i_Load_Store_Type(i_Load_Store_Type), .i_Addr(i_Addr), .i_Store_Data(i_Store_Data),
        .o_Resp_Valid(o_Resp_Valid), .o_Load_Data(o_Load_Data), .o_Fault(o_Fault),
        .o_Mem_Valid(o_Mem_Valid), .i_Mem_Ready(i_Mem_Ready), .o_Mem_Write(o_Mem_Write),
        .o_Mem_Addr(o_Mem_Addr), .o_Mem_Byte_Enable(o_Mem_Byte_Enable), .o_Mem_Write_Data(o_Mem_Write_Data),
        .i_Mem_Resp_Valid(i_Mem_Resp_Valid), .i_Mem_Read_Data(i_Mem_Read_Data)
    );

    initial i_Clock = 1'b0;
    always #5 i_Clock = ~i_Clock;

    int          n_chk = 0, n_err = 0;
    int          beats, mv_cyc, resp_cyc;
    logic [31:0] b_addr[2], b_wd[2];
    logic [3:0]  b_be[2];
    logic        b_wr[2];
    logic [31:0] r_data;
    logic        r_fault, unstable, rdy_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction; memory accepts after `stall` cycles of valid and answers the cycle after handshake.
    task automatic run(input logic [3:0] ty, input logic [31:0] addr, sd, lo_w, hi_w, input int stall);
        int left, pidx;
        logic pend, got, fresh;
        logic [68:0] snap, cur;
        left = stall; pidx = 0; pend = 0; got = 0; fresh = 1; snap = '0;
        beats = 0; mv_cyc = -1; resp_cyc = -1; unstable = 0; rdy_seen = 0; r_data = '0; r_fault = 0;
        @(negedge i_Clock);
        i_Req_Valid = 1; i_Load_Store_Type = ty; i_Addr = addr; i_Store_Data = sd;
        @(posedge i_Clock);
        #1 i_Req_Valid = 0;
        for (int k = 1; k <= 16 && !got; k++) begin
            @(negedge i_Clock);
            i_Mem_Resp_Valid = pend;
            i_Mem_Read_Data  = pend ? (pidx == 0 ? lo_w : hi_w) : 32'h0;
            pend = 0;
            if (o_Req_Ready) rdy_seen = 1;
            if (o_Resp_Valid) begin
                got = 1; resp_cyc = k; r_data = o_Load_Data; r_fault = o_Fault;
            end
            if (o_Mem_Valid) begin
                cur = {o_Mem_Write, o_Mem_Addr, o_Mem_Byte_Enable, o_Mem_Write_Data};
                if (mv_cyc < 0) mv_cyc = k;
                if (fresh) begin snap = cur; fresh = 0; end
                else if (cur !== snap) unstable = 1;
                i_Mem_Ready = (left == 0);
                if (left > 0) left--;
                else begin
                    if (beats < 2) begin
                        b_addr[beats] = o_Mem_Addr; b_be[beats] = o_Mem_Byte_Enable;
                        b_wd[beats] = o_Mem_Write_Data; b_wr[beats] = o_Mem_Write;
                    end
                    pidx = beats; beats++; pend = 1; fresh = 1;
                end
            end else i_Mem_Ready = 1;
        end
        chk("resp_seen", got, 1);
        @(negedge i_Clock);
        i_Mem_Resp_Valid = 0;
        chk("resp_pulse", o_Resp_Valid, 0);
        chk("ready_back", o_Req_Ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        i_Reset = 1; i_Req_Valid = 0; i_Load_Store_Type = '0; i_Addr = '0; i_Store_Data = '0;
        i_Mem_Ready = 1; i_Mem_Resp_Valid = 0; i_Mem_Read_Data = '0;
        repeat (2) @(posedge i_Clock);
        @(negedge i_Clock);
        chk("rst_ready", o_Req_Ready, 1);
        chk("rst_resp", o_Resp_Valid, 0);
        chk("rst_mv", o_Mem_Valid, 0);
        chk("rst_fault", o_Fault, 0);
        chk("rst_bus", {o_Mem_Write, o_Mem_Byte_Enable, o_Mem_Addr | o_Mem_Write_Data | o_Load_Data}, 0);
        i_Reset = 0;

        // Aligned word load: latency and data
        run(LS_TYPE_LOAD_WORD, 32'h100, 0, 32'hDEADBEEF, 0, 0);
        chk("lw_beats", beats, 1);
        chk("lw_addr", b_addr[0], 32'h100);
        chk("lw_wr", b_wr[0], 0);
        chk("lw_mv_cyc", mv_cyc, 1);
        chk("lw_resp_cyc", resp_cyc, 3);
        chk("lw_data", r_data, 32'hDEADBEEF);
        chk("lw_fault", r_fault, 0);

        // Byte store onto the top lane
        run(LS_TYPE_STORE_BYTE, 32'h203, 32'h000000A5, 0, 0, 0);
        chk("sb_addr", b_addr[0], 32'h200);
        chk("sb_be", b_be[0], 4'b1000);
        chk("sb_wd", b_wd[0], 32'hA5000000);
        chk("sb_wr", b_wr[0], 1);
        chk("sb_data", r_data, 0);

        run(LS_TYPE_STORE_HALF, 32'h302, 32'h00001234, 0, 0, 0);
        chk("sh_addr", b_addr[0], 32'h300);
        chk("sh_be", b_be[0], 4'b1100);
        chk("sh_wd", b_wd[0], 32'h12340000);

        // Sign vs zero extension
        run(LS_TYPE_LOAD_BYTE, 32'h101, 0, 32'h00008000, 0, 0);
        chk("lb_data", r_data, 32'hFFFFFF80);
        run(LS_TYPE_LOAD_BYTE_UNSIGNED, 32'h101, 0, 32'h00008000, 0, 0);
        chk("lbu_data", r_data, 32'h00000080);
        run(LS_TYPE_LOAD_HALF, 32'h102, 0, 32'h80010000, 0, 0);
        chk("lh_data", r_data, 32'hFFFF8001);
        run(LS_TYPE_LOAD_HALF_UNSIGNED, 32'h102, 0, 32'h80010000, 0, 0);
        chk("lhu_data", r_data, 32'h00008001);

        // Invalid type code faults without a memory beat
        run(4'hF, 32'h100, 0, 0, 0, 0);
        chk("bad_fault", r_fault, 1);
        chk("bad_beats", beats, 0);
        chk("bad_resp_cyc", resp_cyc, 1);
        chk("bad_data", r_data, 0);

`ifdef LSU_MISALIGNED_SPLIT_EN
        run(LS_TYPE_LOAD_HALF, 32'h103, 0, 32'hAB000000, 32'h000000CD, 0);
        chk("mis_beats", beats, 2);
        chk("mis_addr0", b_addr[0], 32'h100);
        chk("mis_be0", b_be[0], 4'b1000);
        chk("mis_addr1", b_addr[1], 32'h104);
        chk("mis_be1", b_be[1], 4'b0001);
        chk("mis_resp_cyc", resp_cyc, 5);
        chk("mis_data", r_data, 32'hFFFFCDAB);
        chk("mis_fault", r_fault, 0);
        run(LS_TYPE_STORE_WORD, 32'h0FE, 32'h11223344, 0, 0, 0);
        chk("msw_addr0", b_addr[0], 32'h0FC);
        chk("msw_be0", b_be[0], 4'b1100);
        chk("msw_wd0", b_wd[0], 32'h33440000);
        chk("msw_addr1", b_addr[1], 32'h100);
        chk("msw_be1", b_be[1], 4'b0011);
        chk("msw_wd1", b_wd[1], 32'h00001122);
        chk("msw_wr1", b_wr[1], 1);
        run(LS_TYPE_LOAD_WORD, 32'hFFFFFFFD, 0, 32'h11223344, 32'h55667788, 0);
        chk("wrap_addr1", b_addr[1], 32'h0);
        chk("wrap_data", r_data, 32'h88112233);
`else
        run(LS_TYPE_LOAD_HALF, 32'h103, 0, 32'hAB000000, 32'h000000CD, 0);
        chk("mis_fault", r_fault, 1);
        chk("mis_beats", beats, 0);
        chk("mis_resp_cyc", resp_cyc, 1);
        chk("mis_data", r_data, 0);
        run(LS_TYPE_STORE_WORD, 32'h0FE, 32'h11223344, 0, 0, 0);
        chk("msw_fault", r_fault, 1);
        chk("msw_beats", beats, 0);
`endif

        // Memory holds off ready for 5 cycles
        run(LS_TYPE_LOAD_WORD, 32'h100, 0, 32'h0BADCAFE, 0, 5);
        chk("stall_stable", unstable, 0);
        chk("stall_ready_low", rdy_seen, 0);
        chk("stall_beats", beats, 1);
        chk("stall_resp_cyc", resp_cyc, 8);
        chk("stall_data", r_data, 32'h0BADCAFE);

        // Reset while waiting for the LO response; the late response must be dropped
        @(negedge i_Clock);
        i_Req_Valid = 1; i_Load_Store_Type = LS_TYPE_LOAD_WORD; i_Addr = 32'h100; i_Mem_Ready = 1;
        @(posedge i_Clock);
        #1 i_Req_Valid = 0;
        @(negedge i_Clock);
        chk("rstmid_mv", o_Mem_Valid, 1);
        @(negedge i_Clock);
        chk("rstmid_wait", o_Mem_Valid, 0);
        i_Reset = 1;
        @(negedge i_Clock);
        i_Reset = 0; i_Mem_Resp_Valid = 1; i_Mem_Read_Data = 32'h12345678;
        chk("rstmid_ready", o_Req_Ready, 1);
        chk("rstmid_resp0", o_Resp_Valid, 0);
        @(negedge i_Clock);
        i_Mem_Resp_Valid = 0;
        chk("rstmid_resp1", o_Resp_Valid, 0);
        chk("rstmid_idle_mv", o_Mem_Valid, 0);

        run(LS_TYPE_LOAD_WORD, 32'h200, 0, 32'h0BADF00D, 0, 0);
        chk("recover_data", r_data, 32'h0BADF00D);
        chk("recover_resp_cyc", resp_cyc, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
